tour_cmd_sequencer: RTL
=======================

Name: tour_cmd_sequencer

Overview:
- Host-side controller that queues 16-bit Knight commands (calibrate, move, tour) and issues them one at a time to RemoteComm.
- Waits for each command's response and checks it; a timeout or a wrong response halts the sequence with an error code.
- Sits between the test/host logic and RemoteComm. It replaces ad-hoc send/wait tasks with a synthesizable scheduler.

Parameters:
- DEPTH, 16, command queue entries (power of 2).
- TMO_CYC, 10_000_000, clocks allowed per response (reloaded per response).
- ACK_DONE, 8'hA5, final response that completes a command.
- ACK_STEP, 8'h5A, intermediate response; legal only for tour commands (cmd[15:12]==4'h4).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- push  in  1  enqueue push_cmd this cycle
- push_cmd  in  16  command to enqueue
- full  out  1  queue holds DEPTH entries
- count  out  $clog2(DEPTH)+1  entries queued
- start  in  1  pulse: begin issuing queue contents
- abort  in  1  pulse: stop and flush queue
- busy  out  1  high in any state other than IDLE/DONE/ERROR
- done  out  1  one-cycle pulse, queue drained successfully
- err  out  1  sticky error, cleared by start or rst
- err_code  out  2  0 none, 1 timeout, 2 bad resp, 3 push overflow
- cmds_done  out  8  commands completed since last start (saturates 255)
- cmd  out  16  command to RemoteComm
- send_cmd  out  1  one-cycle send strobe to RemoteComm
- cmd_sent  in  1  RemoteComm finished transmitting
- resp_rdy  in  1  RemoteComm response valid (pulse)
- resp  in  8  response byte

Behaviour:
- Reset values: full=0, count=0, busy=0, done=0, err=0, err_code=0, cmds_done=0, cmd=0, send_cmd=0. State=IDLE, queue empty, timer=0.
- Queue (FIFO):
  - Push when not full writes the entry.
  - Push when full is dropped and sets err=1, err_code=3. The state is unaffected.
  - Pop occurs on ISSUE entry. Simultaneous push and pop are legal; count is unchanged.
  - Read/write pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_SENT, WAIT_RESP, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - If queue is non-empty: clear err, err_code and cmds_done; go to ISSUE next cycle.
  - If queue is empty: go to DONE and pulse done for one cycle.
  - start while busy is ignored.
- ISSUE:
  - cmd is loaded with the queue head (popped).
  - send_cmd=1 for exactly this one cycle; timer cleared; go to WAIT_SENT.
  - cmd holds stable until the next ISSUE.
- WAIT_SENT:
  - On cmd_sent, go to WAIT_RESP with timer cleared.
  - resp_rdy in this state is ignored.
- WAIT_RESP, on resp_rdy:
  - resp==ACK_DONE: cmds_done++. Go to ISSUE if the queue is non-empty, else to DONE (done pulse on entry).
  - resp==ACK_STEP and the current command is a tour command: stay in WAIT_RESP and clear the timer.
  - Any other value, or ACK_STEP on a non-tour command: go to ERROR with err_code=2.
- Timer:
  - Increments each cycle in WAIT_SENT and WAIT_RESP.
  - Reaching TMO_CYC-1 without the awaited event sends the FSM to ERROR with err_code=1.
  - Timer width is $clog2(TMO_CYC).
- ERROR: err=1. The queue is retained so the host can inspect count. Leave via start or abort.
- abort in any state:
  - Next state is IDLE; queue is flushed (count=0); send_cmd is forced 0.
  - err is preserved.
  - abort has priority over start, push and all responses in the same cycle.
- Latency: start to first send_cmd is 2 cycles. ACK_DONE to the next send_cmd is 2 cycles.
- Reset mid-operation returns everything to reset values immediately, since rst is asynchronous.

Decomposition:
- Package tour_seq_pkg holds:
  - state enum tseq_state_t;
  - err_code localparams ERR_NONE/ERR_TMO/ERR_RESP/ERR_OVF;
  - opcode constant OP_TOUR=4'h4.
- One sub-module: cmd_fifo (parameterized DEPTH×16 FIFO with full/count). The FSM and timer stay in the top.

Test Plan:
- Push 16'h0000, 16'h3001, start; model replies A5 to each → two send_cmd pulses with cmd 0000 then 3001; done pulse; cmds_done=2; err=0.
- Push 16'h4022, start; model replies 5A ×3 then A5 → stays busy through the steps; done pulse; cmds_done=1.
- Push 16'h3001, start; model asserts cmd_sent but never resp_rdy → ERROR after TMO_CYC (use TMO_CYC=100 in bench); err=1, err_code=1.
- Push 16'h3001, start; model replies 5A → ERROR with err_code=2. Push 17 commands with DEPTH=16 → full=1, err_code=3, count=16.
- Queue 3 commands, start, abort during WAIT_RESP of the first → IDLE next cycle, count=0, no further send_cmd; start with empty queue → done pulse, no send_cmd.
- Assert rst in WAIT_SENT → all outputs at reset values the same cycle; a later start with an empty queue yields only a done pulse.

Source files
------------

// File: rtl/tour_seq_pkg.sv
// Shared types and constants for the Knight command sequencer.
package tour_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitSent,
      StWaitResp,
      StDone,
      StError
   } tseq_state_t;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_TMO  = 2'd1;
   localparam logic [1:0] ERR_RESP = 2'd2;
   localparam logic [1:0] ERR_OVF  = 2'd3;

   localparam logic [3:0] OP_TOUR = 4'h4;

   // Tour commands are the only ones that may report intermediate steps.
   function automatic logic is_tour(input logic [15:0] c);
      return c[15:12] == OP_TOUR;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO with occupancy count; DEPTH must be a power of two.
module cmd_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   // Flush wins; a push into a full queue is dropped here and flagged by the owner.
   assign wr_en = push && !full && !flush;
   assign rd_en = pop && !empty && !flush;

   assign full  = (count == (AW + 1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Storage array, no reset needed since contents are qualified by count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally at DEPTH; simultaneous push/pop keeps count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (wr_en && !rd_en) begin
            count <= count + 1'b1;
         end else if (!wr_en && rd_en) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Queues Knight commands and issues them one at a time to RemoteComm,
// checking each response and halting on timeout or bad response.
module tour_cmd_sequencer
   import tour_seq_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned TMO_CYC  = 10_000_000,
   parameter logic [7:0]  ACK_DONE = 8'hA5,
   parameter logic [7:0]  ACK_STEP = 8'h5A
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [15:0]              push_cmd,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     start,
   input  logic                     abort,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [1:0]               err_code,
   output logic [7:0]               cmds_done,
   output logic [15:0]              cmd,
   output logic                     send_cmd,
   input  logic                     cmd_sent,
   input  logic                     resp_rdy,
   input  logic [7:0]               resp
);

   localparam int unsigned     TW       = $clog2(TMO_CYC);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TMO_CYC - 1);

   tseq_state_t   state;
   logic [TW-1:0] timer;
   logic          q_empty;
   logic          q_pop;
   logic [15:0]   q_head;

   // The head is consumed on the cycle the FSM sits in ISSUE.
   assign q_pop = (state == StIssue);
   assign busy  = !((state == StIdle) || (state == StDone) || (state == StError));

   cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_cmd_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (abort),
      .push      (push),
      .push_data (push_cmd),
      .pop       (q_pop),
      .head      (q_head),
      .full      (full),
      .empty     (q_empty),
      .count     (count)
   );

   // Sequencer FSM, response timer and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         timer     <= '0;
         cmd       <= '0;
         send_cmd  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
         cmds_done <= '0;
      end else begin
         send_cmd <= 1'b0;
         done     <= 1'b0;
         if (abort) begin
            // Abort outranks everything else; err/err_code are left intact.
            state <= StIdle;
            timer <= '0;
         end else begin
            unique case (state)
               StIdle, StDone, StError: begin
                  if (start) begin
                     err       <= 1'b0;
                     err_code  <= ERR_NONE;
                     cmds_done <= '0;
                     if (q_empty) begin
                        state <= StDone;
                        done  <= 1'b1;
                     end else begin
                        state <= StIssue;
                     end
                  end
               end
               StIssue: begin
                  cmd      <= q_head;
                  send_cmd <= 1'b1;
                  timer    <= '0;
                  state    <= StWaitSent;
               end
               StWaitSent: begin
                  if (cmd_sent) begin
                     timer <= '0;
                     state <= StWaitResp;
                  end else if (timer == TMO_LAST) begin
                     state    <= StError;
                     err      <= 1'b1;
                     err_code <= ERR_TMO;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               StWaitResp: begin
                  if (resp_rdy) begin
                     if (resp == ACK_DONE) begin
                        if (cmds_done != 8'hFF) begin
                           cmds_done <= cmds_done + 1'b1;
                        end
                        if (q_empty) begin
                           state <= StDone;
                           done  <= 1'b1;
                        end else begin
                           state <= StIssue;
                        end
                     end else if ((resp == ACK_STEP) && is_tour(cmd)) begin
                        // Progress report: the next response gets a fresh budget.
                        timer <= '0;
                     end else begin
                        state    <= StError;
                        err      <= 1'b1;
                        err_code <= ERR_RESP;
                     end
                  end else if (timer == TMO_LAST) begin
                     state    <= StError;
                     err      <= 1'b1;
                     err_code <= ERR_TMO;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               default: state <= StIdle;
            endcase
            // Overflow is flagged without disturbing the FSM state.
            if (push && full) begin
               err      <= 1'b1;
               err_code <= ERR_OVF;
            end
         end
      end
   end

endmodule
